// File: rtl/wave_capture_ctrl_pkg.sv
// Shared definitions for the wave capture controller.
//   DEF_SAMPLE_W / DEF_ADDR_W / DEF_TRIG_TMO : default widths and trigger timeout
//   cap_state_e      : controller state encoding (2'd3 is illegal)
//   to_offset_binary : top byte of a two's-complement sample -> offset-binary byte
package wave_capture_ctrl_pkg;

   localparam int DEF_SAMPLE_W = 16;
   localparam int DEF_ADDR_W   = 8;
   localparam int DEF_TRIG_TMO = 4096;

   typedef enum logic [1:0] {
      ST_ARMED  = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_WAIT   = 2'd2
   } cap_state_e;

   // Flipping the sign bit maps -128..127 onto 0..255, so silence sits at 8'h80.
   function automatic logic [7:0] to_offset_binary(input logic [7:0] top8);
      return {~top8[7], top8[6:0]};
   endfunction

endpackage

// File: rtl/wave_capture_ctrl_if.sv
// Bus between the codec/display side and the capture controller.
//   new_sample_ready  : strobe, new_sample_in is valid in this cycle
//   new_sample_in     : signed audio sample
//   wave_display_idle : display is blanking, halves may be swapped
//   write_address/write_enable/write_sample : sample RAM write port
//   read_index        : half the display reads
//   capturing, fsm_state : status / debug
// Handshake: new_sample_ready is a valid-only strobe with no ready return path;
// the controller takes every strobe, including strobes on consecutive cycles.
// write_enable is a one-cycle valid for write_address/write_sample; the RAM
// port is assumed always ready.
// master drives the sample stream and idle flag; slave is the controller.
interface wave_capture_if #(
   parameter int SAMPLE_W = 16,
   parameter int ADDR_W   = 8
);
   logic                       new_sample_ready;
   logic signed [SAMPLE_W-1:0] new_sample_in;
   logic                       wave_display_idle;
   logic [ADDR_W:0]            write_address;
   logic                       write_enable;
   logic [7:0]                 write_sample;
   logic                       read_index;
   logic                       capturing;
   logic [1:0]                 fsm_state;

   modport master (
      output new_sample_ready, new_sample_in, wave_display_idle,
      input  write_address, write_enable, write_sample, read_index, capturing, fsm_state
   );

   modport slave (
      input  new_sample_ready, new_sample_in, wave_display_idle,
      output write_address, write_enable, write_sample, read_index, capturing, fsm_state
   );
endinterface

// File: rtl/dffr.sv
// Register with synchronous active-high reset.
//   clk, reset : clock, synchronous reset to RST_VAL
//   d, q       : W-bit data in / out
module dffr #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (reset) q <= RST_VAL;
      else       q <= d;
   end
endmodule

// File: rtl/dffre.sv
// Register with synchronous active-high reset and load enable.
//   clk, reset : clock, synchronous reset to RST_VAL (wins over en)
//   en         : load d when high, otherwise hold
//   d, q       : W-bit data in / out
module dffre #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (reset)   q <= RST_VAL;
      else if (en) q <= d;
   end
endmodule

// File: rtl/wave_capture_ctrl_zero_cross.sv
// Positive zero-crossing detector.
//   clk, reset   : clock, synchronous reset (previous sample reads as 0)
//   sample_valid : current sample is accepted; previous sample updates
//   sample       : current signed sample
//   trigger      : previous accepted sample < 0 and current sample >= 0
//                  (combinational from the current sample)
module zero_cross_detect #(
   parameter int SAMPLE_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sample_valid,
   input  logic signed [SAMPLE_W-1:0] sample,
   output logic                       trigger
);
   // The crossing test depends only on the sign of the previous sample, so
   // only its sign bit is held. A reset value of 0 (non-negative) means the
   // first sample after reset can never trigger.
   logic prev_neg;

   dffre #(.W(1)) u_prev (
      .clk   (clk),
      .reset (reset),
      .en    (sample_valid),
      .d     (sample[SAMPLE_W-1]),
      .q     (prev_neg)
   );

   assign trigger = prev_neg & ~sample[SAMPLE_W-1];
endmodule

// File: rtl/wave_capture_ctrl.sv
// Double-buffered wave capture sequencer.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : slave side of wave_capture_if (sample stream in, RAM write port,
//                read_index, capturing and fsm_state status out)
// Waits for a positive zero crossing (or a free-run timeout), writes one window
// of 2^ADDR_W samples into the half the display is not reading, then swaps
// halves only while the display is idle.
module wave_capture_ctrl
   import wave_capture_ctrl_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int TRIG_TMO = DEF_TRIG_TMO
) (
   input  logic         clk,
   input  logic         reset,
   wave_capture_if.slave bus
);
   localparam int                TMO_W    = $clog2(TRIG_TMO);
   localparam logic [ADDR_W-1:0] LAST_IDX = '1;
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TRIG_TMO - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] index_q, wr_idx;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              read_index_q;
   logic              accept, trigger, start;
   logic              wr_now, tmo_en, flip;

   assign accept = bus.new_sample_ready;

   zero_cross_detect #(.SAMPLE_W(SAMPLE_W)) u_zc (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (accept),
      .sample       (bus.new_sample_in),
      .trigger      (trigger)
   );

   // A window starts on a crossing, or on the sample that finds the timeout
   // counter already at its last value.
   assign start = trigger | (tmo_q == TMO_LAST);

   // State register.
   dffr #(.W(2), .RST_VAL(2'd0)) u_state (
      .clk(clk), .reset(reset), .d(state_d), .q(state_q)
   );

   // Next state. The swap is only considered from WAIT, so an idle flag that
   // coincides with the final write cannot flip read_index on that edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ARMED:  if (accept && start) state_d = ST_ACTIVE;
         ST_ACTIVE: if (accept && index_q == LAST_IDX) state_d = ST_WAIT;
         ST_WAIT:   if (bus.wave_display_idle) state_d = ST_ARMED;
         default:   state_d = ST_ARMED;
      endcase
   end

   // Per-state datapath controls.
   always_comb begin
      wr_now = 1'b0;
      wr_idx = '0;
      tmo_en = 1'b0;
      tmo_d  = '0;
      flip   = 1'b0;
      case (state_q)
         ST_ARMED: begin
            tmo_en = accept;
            tmo_d  = start ? '0 : tmo_q + TMO_W'(1);
            wr_now = accept & start;
         end
         ST_ACTIVE: begin
            wr_now = accept;
            wr_idx = index_q;
         end
         ST_WAIT:   flip = bus.wave_display_idle;
         default:   ;
      endcase
   end

   // index_q holds the slot for the next write; the wrap after the last slot
   // is harmless because every window restarts from slot 0.
   dffre #(.W(ADDR_W)) u_index (
      .clk(clk), .reset(reset), .en(wr_now), .d(wr_idx + ADDR_W'(1)), .q(index_q)
   );

   dffre #(.W(TMO_W)) u_tmo (
      .clk(clk), .reset(reset), .en(tmo_en), .d(tmo_d), .q(tmo_q)
   );

   dffre #(.W(1)) u_read_index (
      .clk(clk), .reset(reset), .en(flip), .d(~read_index_q), .q(read_index_q)
   );

   // Registered RAM write port; the half bit is the inverse of read_index at
   // the accepting edge.
   dffr #(.W(1)) u_we (
      .clk(clk), .reset(reset), .d(wr_now), .q(bus.write_enable)
   );

   dffre #(.W(ADDR_W + 1)) u_addr (
      .clk(clk), .reset(reset), .en(wr_now),
      .d({~read_index_q, wr_idx}), .q(bus.write_address)
   );

   dffre #(.W(8)) u_data (
      .clk(clk), .reset(reset), .en(wr_now),
      .d(to_offset_binary(bus.new_sample_in[SAMPLE_W-1 -: 8])), .q(bus.write_sample)
   );

   assign bus.read_index = read_index_q;
   assign bus.capturing  = (state_q == ST_ACTIVE);
   assign bus.fsm_state  = state_q;
endmodule

// File: tb/tb_wave_capture_ctrl.sv
module tb_wave_capture_ctrl;
   localparam int SW     = 16;
   localparam int AW     = 8;
   localparam int TMO    = 4096;
   localparam int WINDOW = 256;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;

   wave_capture_if #(.SAMPLE_W(SW), .ADDR_W(AW)) bus ();

   wave_capture_ctrl #(.SAMPLE_W(SW), .ADDR_W(AW), .TRIG_TMO(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   // Entry: {edge number [36:17], address [16:8], data [7:0]}
   logic [36:0] exp_q[$];
   logic [36:0] act_q[$];

   always @(posedge clk) begin
      #1;
      if (bus.write_enable === 1'b1)
         act_q.push_back({cyc[19:0], bus.write_address, bus.write_sample});
   end

   // ---------------- reference model ----------------
   // Window-level view: filling a window, holding a full window until the
   // display blanks, or looking for a start condition.
   bit m_filling, m_held, m_half;
   int m_count, m_quiet, m_prev;

   task automatic model_reset();
      m_filling = 0; m_held = 0; m_half = 0;
      m_count = 0; m_quiet = 0; m_prev = 0;
   endtask

   function automatic int rnd_sample();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   // ---------------- drivers ----------------
   task automatic step(input bit rdy, input int s, input bit idle);
      int unsigned stamp;
      bit          wr;
      int          idx;
      logic [AW:0] a;
      logic [7:0]  d;
      @(negedge clk);
      bus.new_sample_ready  = rdy;
      bus.new_sample_in     = SW'(s);
      bus.wave_display_idle = idle;
      stamp = cyc + 1;
      wr = 0; idx = 0;
      if (m_held) begin
         if (idle) begin m_half = !m_half; m_held = 0; end
      end else if (m_filling) begin
         if (rdy) begin
            wr = 1; idx = m_count; m_count++;
            if (m_count == WINDOW) begin m_filling = 0; m_held = 1; end
         end
      end else if (rdy) begin
         if ((m_prev < 0 && s >= 0) || m_quiet == TMO - 1) begin
            wr = 1; idx = 0; m_count = 1; m_filling = 1; m_quiet = 0;
         end else begin
            m_quiet++;
         end
      end
      if (wr) begin
         a = {!m_half, 8'(idx)};
         d = 8'((s >>> (SW - 8)) + 128);
         exp_q.push_back({stamp[19:0], a, d});
      end
      if (rdy) m_prev = s;
      @(posedge clk);
      #2;
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      bus.new_sample_ready  = 1'b0;
      bus.new_sample_in     = '0;
      bus.wave_display_idle = 1'b0;
      repeat (n) @(posedge clk);
      #2;
      model_reset();
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [36:0] got, want;
      apply_reset(3);
      checks++;
      if (bus.fsm_state !== 2'd0 || bus.read_index !== 1'b0 || bus.write_enable !== 1'b0 ||
          bus.capturing !== 1'b0 || bus.write_address !== 9'd0 || bus.write_sample !== 8'd0) begin
         errors++;
         $display("FAIL t1_por: got state=%0d ri=%b we=%b cap=%b addr=%h data=%h, expected 0 0 0 0 000 00",
                  bus.fsm_state, bus.read_index, bus.write_enable, bus.capturing,
                  bus.write_address, bus.write_sample);
      end
      release_reset();
      step(1, -100, 0);
      step(1, 50, 0);
      for (int i = 0; i < 20; i++) step(1, rnd_sample(), 0);
      checks++;
      if (bus.capturing !== 1'b1 || bus.fsm_state !== 2'd1) begin
         errors++;
         $display("FAIL t1_active: got cap=%b state=%0d, expected 1 1", bus.capturing, bus.fsm_state);
      end
      apply_reset(3);
      checks++;
      if (bus.fsm_state !== 2'd0 || bus.read_index !== 1'b0 || bus.write_enable !== 1'b0 ||
          bus.capturing !== 1'b0) begin
         errors++;
         $display("FAIL t1_mid_reset: got state=%0d ri=%b we=%b cap=%b, expected 0 0 0 0",
                  bus.fsm_state, bus.read_index, bus.write_enable, bus.capturing);
      end
      release_reset();
      checks++;
      if (act_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL t1_write_count: got %0d, expected %0d", act_q.size(), exp_q.size());
      end
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         got = act_q.pop_front(); want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL t1_write: got edge=%0d addr=%h data=%h, expected edge=%0d addr=%h data=%h",
                     got[36:17], got[16:8], got[7:0], want[36:17], want[16:8], want[7:0]);
         end
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_trigger();
      step(1, -5, 0);
      step(1, -1, 0);
      checks++;
      if (bus.write_enable !== 1'b0) begin
         errors++;
         $display("FAIL t2_no_early_write: got we=%b, expected 0", bus.write_enable);
      end
      step(1, 0, 0);
      checks++;
      if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h100 || bus.write_sample !== 8'h80) begin
         errors++;
         $display("FAIL t2_first_write: got we=%b addr=%h data=%h, expected 1 100 80",
                  bus.write_enable, bus.write_address, bus.write_sample);
      end
   endtask

   task automatic test_full_window();
      logic [36:0] got, want;
      int guard = 0;
      while (m_filling && guard < 3000) begin
         step($urandom_range(0, 3) != 0, rnd_sample(), 0);
         guard++;
      end
      checks++;
      if (act_q.size() != WINDOW) begin
         errors++;
         $display("FAIL t3_window_size: got %0d writes, expected %0d", act_q.size(), WINDOW);
      end
      for (int i = 0; i < act_q.size(); i++) begin
         checks++;
         if (act_q[i][16:8] !== {1'b1, 8'(i)}) begin
            errors++;
            $display("FAIL t3_addr_order: got %h at write %0d, expected %h", act_q[i][16:8], i, {1'b1, 8'(i)});
         end
      end
      for (int i = 0; i < 30; i++) step(1, rnd_sample(), 0);
      checks++;
      if (bus.fsm_state !== 2'd2) begin
         errors++;
         $display("FAIL t3_wait_state: got %0d, expected 2", bus.fsm_state);
      end
      checks++;
      if (act_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL t3_write_count: got %0d, expected %0d", act_q.size(), exp_q.size());
      end
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         got = act_q.pop_front(); want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL t3_write: got edge=%0d addr=%h data=%h, expected edge=%0d addr=%h data=%h",
                     got[36:17], got[16:8], got[7:0], want[36:17], want[16:8], want[7:0]);
         end
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_swap();
      logic [36:0] got, want;
      int guard = 0;
      for (int i = 0; i < 50; i++) begin
         step($urandom_range(0, 1), rnd_sample(), 0);
         checks++;
         if (bus.read_index !== 1'b0) begin
            errors++;
            $display("FAIL t4_hold: got ri=%b at cycle %0d, expected 0", bus.read_index, i);
         end
      end
      step(0, 0, 1);
      checks++;
      if (bus.read_index !== 1'b1 || bus.fsm_state !== 2'd0) begin
         errors++;
         $display("FAIL t4_flip: got ri=%b state=%0d, expected 1 0", bus.read_index, bus.fsm_state);
      end
      step(1, -20, 0);
      step(1, 20, 0);
      while (m_filling && guard < 3000) begin
         step($urandom_range(0, 2) != 0, rnd_sample(), 0);
         guard++;
      end
      step(1, 7, 0);
      checks++;
      if (act_q.size() != WINDOW) begin
         errors++;
         $display("FAIL t4_window_size: got %0d writes, expected %0d", act_q.size(), WINDOW);
      end
      for (int i = 0; i < act_q.size(); i++) begin
         checks++;
         if (act_q[i][16] !== 1'b0) begin
            errors++;
            $display("FAIL t4_half: got addr %h at write %0d, expected half 0", act_q[i][16:8], i);
         end
      end
      step(0, 0, 1);
      checks++;
      if (bus.read_index !== 1'b0) begin
         errors++;
         $display("FAIL t4_flip_back: got ri=%b, expected 0", bus.read_index);
      end
      checks++;
      if (act_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL t4_write_count: got %0d, expected %0d", act_q.size(), exp_q.size());
      end
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         got = act_q.pop_front(); want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL t4_write: got edge=%0d addr=%h data=%h, expected edge=%0d addr=%h data=%h",
                     got[36:17], got[16:8], got[7:0], want[36:17], want[16:8], want[7:0]);
         end
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_timeout();
      logic [36:0] got, want;
      int first_k = 0;
      for (int k = 1; k <= TMO + WINDOW + 10; k++) begin
         step(1, 100, 0);
         if (first_k == 0 && act_q.size() > 0) first_k = k;
      end
      checks++;
      if (first_k != TMO) begin
         errors++;
         $display("FAIL t5_free_run_start: got first write on strobe %0d, expected %0d", first_k, TMO);
      end
      checks++;
      if (act_q.size() != WINDOW) begin
         errors++;
         $display("FAIL t5_window_size: got %0d writes, expected %0d", act_q.size(), WINDOW);
      end
      for (int i = 0; i < act_q.size(); i++) begin
         checks++;
         if (act_q[i][7:0] !== 8'h80) begin
            errors++;
            $display("FAIL t5_data: got %h at write %0d, expected 80", act_q[i][7:0], i);
         end
      end
      checks++;
      if (act_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL t5_write_count: got %0d, expected %0d", act_q.size(), exp_q.size());
      end
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         got = act_q.pop_front(); want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL t5_write: got edge=%0d addr=%h data=%h, expected edge=%0d addr=%h data=%h",
                     got[36:17], got[16:8], got[7:0], want[36:17], want[16:8], want[7:0]);
         end
      end
      act_q.delete(); exp_q.delete();
      step(0, 0, 1);
   endtask

   task automatic test_simultaneous();
      logic [36:0] got, want;
      bit old_half;
      int guard = 0;
      step(1, -3, 0);
      step(1, 3, 0);
      while (m_filling && m_count < WINDOW - 1 && guard < 3000) begin
         step($urandom_range(0, 3) != 0, rnd_sample(), 0);
         guard++;
      end
      old_half = m_half;
      step(1, rnd_sample(), 1);
      checks++;
      if (bus.write_enable !== 1'b1 || bus.write_address[7:0] !== 8'hFF ||
          bus.read_index !== old_half || bus.fsm_state !== 2'd2) begin
         errors++;
         $display("FAIL t6_last_write: got we=%b idx=%h ri=%b state=%0d, expected 1 ff %b 2",
                  bus.write_enable, bus.write_address[7:0], bus.read_index, bus.fsm_state, old_half);
      end
      step(0, 0, 1);
      checks++;
      if (bus.write_enable !== 1'b0 || bus.read_index !== !old_half || bus.fsm_state !== 2'd0) begin
         errors++;
         $display("FAIL t6_flip_after: got we=%b ri=%b state=%0d, expected 0 %b 0",
                  bus.write_enable, bus.read_index, bus.fsm_state, !old_half);
      end
      checks++;
      if (act_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL t6_write_count: got %0d, expected %0d", act_q.size(), exp_q.size());
      end
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         got = act_q.pop_front(); want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL t6_write: got edge=%0d addr=%h data=%h, expected edge=%0d addr=%h data=%h",
                     got[36:17], got[16:8], got[7:0], want[36:17], want[16:8], want[7:0]);
         end
      end
      act_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [36:0] got, want;
      int s;
      for (int i = 0; i < 3000; i++) begin
         s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 600)) - 300 : rnd_sample();
         step($urandom_range(0, 4) != 0, s, $urandom_range(0, 9) == 0);
         checks++;
         if (bus.read_index !== m_half || bus.capturing !== m_filling) begin
            errors++;
            $display("FAIL b2b_status: got ri=%b cap=%b at step %0d, expected %b %b",
                     bus.read_index, bus.capturing, i, m_half, m_filling);
         end
      end
      checks++;
      if (act_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL b2b_write_count: got %0d, expected %0d", act_q.size(), exp_q.size());
      end
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         got = act_q.pop_front(); want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL b2b_write: got edge=%0d addr=%h data=%h, expected edge=%0d addr=%h data=%h",
                     got[36:17], got[16:8], got[7:0], want[36:17], want[16:8], want[7:0]);
         end
      end
      act_q.delete(); exp_q.delete();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      bus.new_sample_ready  = 1'b0;
      bus.new_sample_in     = '0;
      bus.wave_display_idle = 1'b0;
      model_reset();
      test_reset();
      test_trigger();
      test_full_window();
      test_swap();
      test_timeout();
      test_simultaneous();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
